// File: rtl/y_out_stage.sv
// FP16 output stage: y[g] = hC_sum[g] + D[head(g)] * x[g], streamed one element per cycle
// through a fixed-latency multiplier and adder, with results scattered back into y_flat.

module fp16_mult_wrapper #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        valid_in,
    output logic [15:0] result,
    output logic        valid_out
);
    // Round-to-nearest-even product; subnormal operands and results flush to zero.
    function automatic logic [15:0] f16_mul(input logic [15:0] fa, input logic [15:0] fb);
        logic              s;
        logic [21:0]       prod;
        logic [10:0]       m;
        logic [11:0]       mr;
        logic              g;
        logic              st;
        logic signed [7:0] e;
        logic [15:0]       r;
        s    = fa[15] ^ fb[15];
        prod = 22'd0;
        m    = 11'd0;
        mr   = 12'd0;
        g    = 1'b0;
        st   = 1'b0;
        e    = 8'sd0;
        r    = 16'h0000;
        if ((fa[14:10] == 5'h1F && fa[9:0] != 10'd0) || (fb[14:10] == 5'h1F && fb[9:0] != 10'd0)) begin
            r = 16'h7E00;
        end else if (fa[14:10] == 5'h1F || fb[14:10] == 5'h1F) begin
            r = (fa[14:10] == 5'd0 || fb[14:10] == 5'd0) ? 16'h7E00 : {s, 5'h1F, 10'd0};
        end else if (fa[14:10] == 5'd0 || fb[14:10] == 5'd0) begin
            r = {s, 15'd0};
        end else begin
            prod = {11'd0, 1'b1, fa[9:0]} * {11'd0, 1'b1, fb[9:0]};
            e    = $signed({3'b000, fa[14:10]}) + $signed({3'b000, fb[14:10]}) - 8'sd15;
            if (prod[21]) begin
                m  = prod[21:11];
                g  = prod[10];
                st = |prod[9:0];
                e  = e + 8'sd1;
            end else begin
                m  = prod[20:10];
                g  = prod[9];
                st = |prod[8:0];
            end
            mr = {1'b0, m} + {11'd0, g & (st | m[0])};
            if (mr[11]) begin
                mr = mr >> 1;
                e  = e + 8'sd1;
            end
            if (e >= 8'sd31)     r = {s, 5'h1F, 10'd0};
            else if (e <= 8'sd0) r = {s, 15'd0};
            else                 r = {s, e[4:0], mr[9:0]};
        end
        return r;
    endfunction

    logic [15:0]    r_res [LAT];
    logic [LAT-1:0] r_vld;

    // Fixed-latency result and valid delay line.
    always_ff @(posedge clk) begin
        r_res[0] <= f16_mul(a, b);
        r_vld[0] <= valid_in;
        for (int i = 1; i < LAT; i++) begin
            r_res[i] <= r_res[i-1];
            r_vld[i] <= r_vld[i-1];
        end
    end

    assign result    = r_res[LAT-1];
    assign valid_out = r_vld[LAT-1];
endmodule

module fp16_add_wrapper #(
    parameter int LAT = 11
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        valid_in,
    output logic [15:0] result,
    output logic        valid_out
);
    // Round-to-nearest-even sum with 3 guard bits; exact cancellation gives +0.
    function automatic logic [15:0] f16_add(input logic [15:0] fa, input logic [15:0] fb);
        logic [15:0]       r;
        logic [15:0]       x;
        logic [15:0]       y;
        logic [13:0]       mx;
        logic [13:0]       my;
        logic [13:0]       msh;
        logic [13:0]       mask;
        logic [14:0]       sum;
        logic [4:0]        d;
        logic signed [7:0] e;
        logic [10:0]       m;
        logic [11:0]       mr;
        logic              g;
        logic              st;
        r = 16'h0000; x = fa; y = fb; mx = 14'd0; my = 14'd0; msh = 14'd0; mask = 14'd0;
        sum = 15'd0; d = 5'd0; e = 8'sd0; m = 11'd0; mr = 12'd0; g = 1'b0; st = 1'b0;
        if ((fa[14:10] == 5'h1F && fa[9:0] != 10'd0) || (fb[14:10] == 5'h1F && fb[9:0] != 10'd0)) begin
            r = 16'h7E00;
        end else if (fa[14:10] == 5'h1F && fb[14:10] == 5'h1F) begin
            r = (fa[15] != fb[15]) ? 16'h7E00 : fa;
        end else if (fa[14:10] == 5'h1F) begin
            r = fa;
        end else if (fb[14:10] == 5'h1F) begin
            r = fb;
        end else if (fa[14:10] == 5'd0 && fb[14:10] == 5'd0) begin
            r = {fa[15] & fb[15], 15'd0};
        end else if (fa[14:10] == 5'd0) begin
            r = fb;
        end else if (fb[14:10] == 5'd0) begin
            r = fa;
        end else begin
            if (fa[14:0] < fb[14:0]) begin
                x = fb;
                y = fa;
            end
            d  = x[14:10] - y[14:10];
            mx = {1'b1, x[9:0], 3'b000};
            my = {1'b1, y[9:0], 3'b000};
            if (d >= 5'd14) begin
                msh = 14'd1;
            end else begin
                mask = (14'd1 << d) - 14'd1;
                msh  = (my >> d) | {13'd0, |(my & mask)};
            end
            e = $signed({3'b000, x[14:10]});
            if (x[15] == y[15]) begin
                sum = {1'b0, mx} + {1'b0, msh};
                if (sum[14]) begin
                    sum = {1'b0, sum[14:2], sum[1] | sum[0]};
                    e   = e + 8'sd1;
                end
            end else begin
                sum = {1'b0, mx} - {1'b0, msh};
                for (int i = 0; i < 13; i++) begin
                    if (!sum[13] && sum != 15'd0) begin
                        sum = sum << 1;
                        e   = e - 8'sd1;
                    end
                end
            end
            if (sum == 15'd0) begin
                r = 16'h0000;
            end else begin
                m  = sum[13:3];
                g  = sum[2];
                st = |sum[1:0];
                mr = {1'b0, m} + {11'd0, g & (st | m[0])};
                if (mr[11]) begin
                    mr = mr >> 1;
                    e  = e + 8'sd1;
                end
                if (e >= 8'sd31)     r = {x[15], 5'h1F, 10'd0};
                else if (e <= 8'sd0) r = {x[15], 15'd0};
                else                 r = {x[15], e[4:0], mr[9:0]};
            end
        end
        return r;
    endfunction

    logic [15:0]    r_res [LAT];
    logic [LAT-1:0] r_vld;

    // Fixed-latency result and valid delay line.
    always_ff @(posedge clk) begin
        r_res[0] <= f16_add(a, b);
        r_vld[0] <= valid_in;
        for (int i = 1; i < LAT; i++) begin
            r_res[i] <= r_res[i-1];
            r_vld[i] <= r_vld[i-1];
        end
    end

    assign result    = r_res[LAT-1];
    assign valid_out = r_vld[LAT-1];
endmodule

module y_out_stage #(
    parameter int B       = 1,
    parameter int H       = 4,
    parameter int P       = 4,
    parameter int DW      = 16,
    parameter int MUL_LAT = 6,
    parameter int ADD_LAT = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [B*H*P*DW-1:0]   hC_sum_flat,
    input  logic [B*H*P*DW-1:0]   x_flat,
    input  logic [H*DW-1:0]       D_flat,
    output logic [B*H*P*DW-1:0]   y_flat,
    output logic                  busy,
    output logic                  done
);
    localparam int T  = B * H * P;
    localparam int CW = $clog2(T) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_issue_idx;
    logic [CW-1:0]    r_write_idx;
    logic [T*DW-1:0]  r_hc;
    logic [T*DW-1:0]  r_x;
    logic [H*DW-1:0]  r_d;
    logic [T*DW-1:0]  r_y;
    logic             r_busy;
    logic             r_done;
    logic [DW-1:0]    r_hc_pipe [MUL_LAT];
    logic [MUL_LAT-1:0] r_hc_vld;
    logic [ADD_LAT-1:0] r_wr_tag;

    int            w_g;
    int            w_h;
    logic [DW-1:0] w_mul_a;
    logic [DW-1:0] w_mul_b;
    logic [DW-1:0] w_hc_in;
    logic [DW-1:0] w_mul_res;
    logic [DW-1:0] w_add_res;
    logic          w_issue_vld;
    logic          w_mul_vld;
    logic          w_add_vin;
    logic          w_add_vld;
    logic          w_wr;

    assign w_issue_vld = (r_state == ISSUE);

    // Operand selection for the element currently being issued.
    always_comb begin
        w_g = 0;
        if (r_issue_idx < CW'(T)) begin
            w_g = int'(r_issue_idx);
        end else begin
            w_g = 0;
        end
        w_h     = (w_g / P) % H;
        w_mul_a = r_d[w_h*DW +: DW];
        w_mul_b = r_x[w_g*DW +: DW];
        w_hc_in = r_hc[w_g*DW +: DW];
    end

    fp16_mult_wrapper #(.LAT(MUL_LAT)) u_mul (
        .clk       (clk),
        .a         (w_mul_a),
        .b         (w_mul_b),
        .valid_in  (w_issue_vld),
        .result    (w_mul_res),
        .valid_out (w_mul_vld)
    );

    // The wrappers have no reset, so writes are also gated by reset-cleared tags.
    assign w_add_vin = w_mul_vld & r_hc_vld[MUL_LAT-1];

    fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
        .clk       (clk),
        .a         (r_hc_pipe[MUL_LAT-1]),
        .b         (w_mul_res),
        .valid_in  (w_add_vin),
        .result    (w_add_res),
        .valid_out (w_add_vld)
    );

    assign w_wr = w_add_vld & r_wr_tag[ADD_LAT-1] & (r_write_idx < CW'(T));

    // hC alignment pipe and write-tag pipe, both cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_hc_pipe[i] <= '0;
            end
            r_hc_vld <= '0;
            r_wr_tag <= '0;
        end else begin
            r_hc_pipe[0] <= w_hc_in;
            r_hc_vld[0]  <= w_issue_vld;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_hc_pipe[i] <= r_hc_pipe[i-1];
                r_hc_vld[i]  <= r_hc_vld[i-1];
            end
            r_wr_tag[0] <= w_add_vin;
            for (int i = 1; i < ADD_LAT; i++) begin
                r_wr_tag[i] <= r_wr_tag[i-1];
            end
        end
    end

    // Control FSM, input capture and result write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_issue_idx <= '0;
            r_write_idx <= '0;
            r_hc        <= '0;
            r_x         <= '0;
            r_d         <= '0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_y[r_write_idx*DW +: DW] <= w_add_res;
                r_write_idx               <= r_write_idx + CW'(1);
            end
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_hc        <= hC_sum_flat;
                        r_x         <= x_flat;
                        r_d         <= D_flat;
                        r_issue_idx <= '0;
                        r_write_idx <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_issue_idx <= r_issue_idx + CW'(1);
                    if (r_issue_idx == CW'(T - 1)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // done lands in the cycle right after the final write.
                    if (w_wr && r_write_idx == CW'(T - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign y_flat = r_y;
    assign busy   = r_busy;
    assign done   = r_done;
endmodule

// File: tb/tb_y_out_stage.sv
// Directed and randomized bench for y_out_stage; values are exact small integers so the
// reference is plain integer arithmetic converted to FP16.

module tb_y_out_stage;
    localparam int B   = 1;
    localparam int H   = 4;
    localparam int P   = 4;
    localparam int DW  = 16;
    localparam int ML  = 6;
    localparam int AL  = 11;
    localparam int T   = B * H * P;
    localparam int LAT = ML + AL;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [T*DW-1:0]  hc_flat = '0;
    logic [T*DW-1:0]  x_flat = '0;
    logic [H*DW-1:0]  d_flat = '0;
    logic [T*DW-1:0]  y_flat;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int hc_i [T];
    int x_i  [T];
    int d_i  [H];
    logic [T*DW-1:0] y_new;
    logic [T*DW-1:0] y_old;
    logic [T*DW-1:0] y_exp;

    y_out_stage #(.B(B), .H(H), .P(P), .DW(DW), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hC_sum_flat (hc_flat),
        .x_flat      (x_flat),
        .D_flat      (d_flat),
        .y_flat      (y_flat),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] i2h(input int v);
        int        m;
        int        e;
        logic [9:0] f;
        if (v == 0) return 16'h0000;
        m = (v < 0) ? -v : v;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        f = 10'((m << (10 - e)) & 1023);
        return {(v < 0) ? 1'b1 : 1'b0, 5'(e + 15), f};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load_and_model();
        for (int g = 0; g < T; g++) begin
            hc_flat[g*DW +: DW] = i2h(hc_i[g]);
            x_flat[g*DW +: DW]  = i2h(x_i[g]);
            y_new[g*DW +: DW]   = i2h(hc_i[g] + d_i[(g / P) % H] * x_i[g]);
        end
        for (int h = 0; h < H; h++) d_flat[h*DW +: DW] = i2h(d_i[h]);
    endtask

    task automatic randomize_model();
        for (int g = 0; g < T; g++) begin
            hc_i[g] = int'($urandom_range(100)) - 50;
            x_i[g]  = int'($urandom_range(16)) - 8;
        end
        for (int h = 0; h < H; h++) d_i[h] = int'($urandom_range(16)) - 8;
    endtask

    // One run: start sampled at edge 0, then per-edge checks of y, busy and done.
    task automatic run(input string tag, input bit perturb);
        int dones;
        dones = 0;
        load_and_model();
        @(negedge clk);
        start = 1'b1;
        y_old = y_flat;
        for (int n = 0; n < 41; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (perturb) begin
                if (n == 4 || n == 19) start = 1'b1;
                hc_flat = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
                x_flat  = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
                d_flat  = {$urandom(), $urandom()};
            end
            for (int k = 0; k < T; k++)
                y_exp[k*DW +: DW] = (n >= 1 + k + LAT) ? y_new[k*DW +: DW] : y_old[k*DW +: DW];
            chk($sformatf("%s_y_edge%0d", tag, n), 256'(y_flat), 256'(y_exp));
            chk($sformatf("%s_busy_cyc%0d", tag, n + 1), 256'(busy),
                256'((n + 1 >= 1 && n + 1 <= T + LAT) ? 1'b1 : 1'b0));
            chk($sformatf("%s_done_cyc%0d", tag, n + 1), 256'(done),
                256'((n + 1 == T + LAT + 1) ? 1'b1 : 1'b0));
            if (done === 1'b1) dones++;
        end
        chk($sformatf("%s_done_count", tag), 256'(dones), 256'(1));
    endtask

    initial begin
        logic [15:0] head_y [4];
        logic [T*DW-1:0] const_exp;
        head_y = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", 256'(y_flat), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_done", 256'(done), 256'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int g = 0; g < T; g++) begin hc_i[g] = 1; x_i[g] = 1; end
        for (int h = 0; h < H; h++) d_i[h] = 2;
        run("ones", 1'b0);
        for (int g = 0; g < T; g++) const_exp[g*DW +: DW] = 16'h4200;
        chk("ones_const", 256'(y_flat), 256'(const_exp));

        d_i[0] = 0; d_i[1] = 1; d_i[2] = 2; d_i[3] = -1;
        run("heads", 1'b0);
        for (int g = 0; g < T; g++) const_exp[g*DW +: DW] = head_y[(g / P) % H];
        chk("heads_const", 256'(y_flat), 256'(const_exp));

        for (int g = 0; g < T; g++) begin hc_i[g] = g; x_i[g] = 0; end
        for (int h = 0; h < H; h++) d_i[h] = 1;
        run("ramp", 1'b0);

        randomize_model();
        run("restart", 1'b1);

        // Abort a run with reset at cycle 10, release at cycle 12.
        randomize_model();
        load_and_model();
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 46; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 9) rst = 1'b0;
            if (n == 11) rst = 1'b1;
            #1;
            if (n >= 9) begin
                chk($sformatf("abort_y_cyc%0d", n + 1), 256'(y_flat), 256'(0));
                chk($sformatf("abort_busy_cyc%0d", n + 1), 256'(busy), 256'(0));
                chk($sformatf("abort_done_cyc%0d", n + 1), 256'(done), 256'(0));
            end
        end

        for (int r = 0; r < 3; r++) begin
            randomize_model();
            run($sformatf("rand%0d", r), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
